// File: rtl/axi_stream_packet_demux.sv
// Packet-granular AXI4-Stream demux: per-packet route taken from a queued select FIFO.
// Optional AXI_DEMUX_STATS_EN adds per-output packet counters and a drop counter.
module axi_stream_packet_demux #(
    parameter int NUM_STREAMS = 4,
    parameter int DATA_BITS   = 512,
    parameter int SEL_DEPTH   = 8,
    parameter int SEL_BITS    = $clog2(NUM_STREAMS) + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [SEL_BITS-1:0]               select_data_i,
    input  logic                              select_valid_i,
    output logic                              select_ready_o,
    input  logic [DATA_BITS-1:0]              in_tdata_i,
    input  logic [DATA_BITS/8-1:0]            in_tkeep_i,
    input  logic                              in_tlast_i,
    input  logic                              in_tvalid_i,
    output logic                              in_tready_o,
    output logic [NUM_STREAMS*DATA_BITS-1:0]  out_tdata_o,
    output logic [NUM_STREAMS*DATA_BITS/8-1:0] out_tkeep_o,
    output logic [NUM_STREAMS-1:0]            out_tlast_o,
    output logic [NUM_STREAMS-1:0]            out_tvalid_o,
    input  logic [NUM_STREAMS-1:0]            out_tready_i,
`ifdef AXI_DEMUX_STATS_EN
    input  logic                              stats_clr_i,
    output logic [NUM_STREAMS*32-1:0]         pkt_count_o,
    output logic [31:0]                       drop_count_o,
`endif
    output logic                              drop_pulse_o
);
    localparam int PTR_BITS = $clog2(SEL_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [SEL_BITS-1:0] NUM_SEL = SEL_BITS'(NUM_STREAMS);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(SEL_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ROUTE, ST_DROP} state_t;

    state_t                state_q, state_d;
    logic [SEL_BITS-1:0]   cur_sel_q, cur_sel_d;
    logic [SEL_BITS-1:0]   fifo_mem_q [SEL_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic                  sel_rdy_q;
    logic                  push, pop, fifo_empty, tlast_hs;
    logic [SEL_BITS-1:0]   fifo_head;
    logic [NUM_STREAMS-1:0] sel_onehot;

    assign push       = select_valid_i & sel_rdy_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem_q[rd_ptr_q];
    assign count_d    = count_q + CNT_BITS'(push) - CNT_BITS'(pop);
    assign select_ready_o = sel_rdy_q;
    assign tlast_hs   = in_tvalid_i & in_tready_o & in_tlast_i & (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= select_data_i;
    end

    // Ready is registered from the next occupancy, so it is already low the cycle after the last slot fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sel_rdy_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            count_q   <= count_d;
            sel_rdy_q <= (count_d != FULL_CNT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        pop       = 1'b0;
        if ((state_q == ST_IDLE) || tlast_hs) begin
            if (!fifo_empty) begin
                pop       = 1'b1;
                cur_sel_d = fifo_head;
                state_d   = (fifo_head < NUM_SEL) ? ST_ROUTE : ST_DROP;
            end else begin
                state_d   = ST_IDLE;
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (cur_sel_q == SEL_BITS'(i)) sel_onehot[i] = 1'b1;
        end
    end

    always_comb begin
        in_tready_o  = 1'b0;
        out_tvalid_o = '0;
        drop_pulse_o = 1'b0;
        case (state_q)
            ST_ROUTE: begin
                out_tvalid_o = in_tvalid_i ? sel_onehot : '0;
                in_tready_o  = |(sel_onehot & out_tready_i);
            end
            ST_DROP: begin
                in_tready_o  = 1'b1;
                drop_pulse_o = in_tvalid_i & in_tlast_i;
            end
            default: ;
        endcase
    end

    assign out_tdata_o = {NUM_STREAMS{in_tdata_i}};
    assign out_tkeep_o = {NUM_STREAMS{in_tkeep_i}};
    assign out_tlast_o = {NUM_STREAMS{in_tlast_i}};

`ifdef AXI_DEMUX_STATS_EN
    logic [31:0] pkt_cnt_q [NUM_STREAMS];
    logic [31:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STREAMS; i++) pkt_cnt_q[i] <= '0;
            drop_cnt_q <= '0;
        end else if (stats_clr_i) begin
            for (int i = 0; i < NUM_STREAMS; i++) pkt_cnt_q[i] <= '0;
            drop_cnt_q <= '0;
        end else if (tlast_hs) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if ((state_q == ST_ROUTE) && sel_onehot[i]) pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
            end
            if (state_q == ST_DROP) drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_pkt_cnt
        assign pkt_count_o[g*32 +: 32] = pkt_cnt_q[g];
    end
    assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_axi_stream_packet_demux.sv
// Randomised bench for axi_stream_packet_demux with a queue-based packet model and
// per-output scoreboards; counter ports are exercised when AXI_DEMUX_STATS_EN is defined.
module tb_axi_stream_packet_demux;
    localparam int NS = 4;
    localparam int DB = 32;
    localparam int KB = DB / 8;
    localparam int SD = 8;
    localparam int SB = $clog2(NS) + 1;

    typedef struct {
        logic [DB-1:0] d;
        logic [KB-1:0] k;
        logic          l;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [SB-1:0]        select_data = '0;
    logic                 select_valid = 1'b0;
    logic                 select_ready;
    logic [DB-1:0]        in_tdata = '0;
    logic [KB-1:0]        in_tkeep = '0;
    logic                 in_tlast = 1'b0;
    logic                 in_tvalid = 1'b0;
    logic                 in_tready;
    logic [NS*DB-1:0]     out_tdata;
    logic [NS*KB-1:0]     out_tkeep;
    logic [NS-1:0]        out_tlast;
    logic [NS-1:0]        out_tvalid;
    logic [NS-1:0]        out_tready = '1;
    logic                 drop_pulse;
`ifdef AXI_DEMUX_STATS_EN
    logic                 stats_clr = 1'b0;
    logic [NS*32-1:0]     pkt_count;
    logic [31:0]          drop_count;
`endif

    axi_stream_packet_demux #(
        .NUM_STREAMS(NS), .DATA_BITS(DB), .SEL_DEPTH(SD), .SEL_BITS(SB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .select_data_i(select_data), .select_valid_i(select_valid), .select_ready_o(select_ready),
        .in_tdata_i(in_tdata), .in_tkeep_i(in_tkeep), .in_tlast_i(in_tlast),
        .in_tvalid_i(in_tvalid), .in_tready_o(in_tready),
        .out_tdata_o(out_tdata), .out_tkeep_o(out_tkeep), .out_tlast_o(out_tlast),
        .out_tvalid_o(out_tvalid), .out_tready_i(out_tready),
`ifdef AXI_DEMUX_STATS_EN
        .stats_clr_i(stats_clr), .pkt_count_o(pkt_count), .drop_count_o(drop_count),
`endif
        .drop_pulse_o(drop_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: accepted selects, destination of the packet in flight (-1 = none), registered ready.
    int  selq[$];
    int  cur = -1;
    bit  srdy_m = 1'b0;
    int unsigned pkt_m[NS];
    int unsigned drop_m = 0;

    beat_t        beat_q[$];
    int           sel_pend[$];
    logic [DB+KB:0] exp_sb[NS][$];
    logic [DB+KB:0] got_sb[NS][$];
    bit           data_en = 1'b1;
    int           gap_pct = 0;
    int           tr_mode = 0;
    bit           tr_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    int cyc, hs_cnt, first_hs, last_hs, drop_cnt_ph, sel_acc_cnt, last_beats;
    int dest_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        selq.delete();
        cur = -1;
        srdy_m = 1'b0;
        for (int i = 0; i < NS; i++) pkt_m[i] = 0;
        drop_m = 0;
    endtask

    task automatic phase_reset();
        cyc = 0; hs_cnt = 0; first_hs = -1; last_hs = -1;
        drop_cnt_ph = 0; sel_acc_cnt = 0; last_beats = 0;
        dest_log.delete();
    endtask

    task automatic push_pkt(input int sel, input int n);
        beat_t b;
        sel_pend.push_back(sel);
        for (int j = 0; j < n; j++) begin
            b.d = DB'($urandom);
            b.k = KB'($urandom_range(1, (1 << KB) - 1));
            b.l = (j == n - 1);
            beat_q.push_back(b);
            if (sel < NS) exp_sb[sel].push_back({b.l, b.k, b.d});
        end
    endtask

    task automatic drive_inputs(input bit pushed, input bit hs_in);
        if (pushed) begin
            void'(sel_pend.pop_front());
            sel_acc_cnt++;
        end
        if (hs_in) void'(beat_q.pop_front());
        if (!(select_valid && !pushed)) begin
            select_valid = (sel_pend.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
            select_data  = (sel_pend.size() > 0) ? SB'(sel_pend[0]) : '0;
        end
        if (!(in_tvalid && !hs_in)) begin
            in_tvalid = data_en && (beat_q.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
            if (beat_q.size() > 0) begin
                in_tdata = beat_q[0].d;
                in_tkeep = beat_q[0].k;
                in_tlast = beat_q[0].l;
            end
        end
        case (tr_mode)
            0:       out_tready = '1;
            1:       out_tready = NS'($urandom);
            default: out_tready = tr_pat[(cyc + 2) % 4] ? '1 : '0;
        endcase
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge, drive after it.
    task automatic step();
        logic [NS-1:0] exp_tv;
        logic          exp_tr, exp_dp;
        bit            pushed, hs_in, m_hs;
        @(negedge clk);
        exp_tr = (cur < 0) ? 1'b0 : ((cur >= NS) ? 1'b1 : out_tready[cur]);
        exp_tv = (cur >= 0 && cur < NS && in_tvalid) ? NS'(1 << cur) : '0;
        exp_dp = (cur >= NS) && in_tvalid && in_tlast;
        chk("select_ready", 64'(select_ready), 64'(srdy_m));
        chk("in_tready", 64'(in_tready), 64'(exp_tr));
        chk("out_tvalid", 64'(out_tvalid), 64'(exp_tv));
        chk("drop_pulse", 64'(drop_pulse), 64'(exp_dp));
        for (int i = 0; i < NS; i++) begin
            if (out_tvalid[i])
                chk("fanout", 64'({out_tlast[i], out_tkeep[i*KB +: KB], out_tdata[i*DB +: DB]}),
                    64'({in_tlast, in_tkeep, in_tdata}));
            if (out_tvalid[i] && out_tready[i]) begin
                got_sb[i].push_back({out_tlast[i], out_tkeep[i*KB +: KB], out_tdata[i*DB +: DB]});
                hs_cnt++;
                if (out_tlast[i]) last_beats++;
                dest_log.push_back(i);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
        end
        if (drop_pulse) drop_cnt_ph++;
        pushed = select_valid && select_ready;
        hs_in  = in_tvalid && in_tready;
        m_hs   = in_tvalid && exp_tr;
        @(posedge clk);
        if (rst_n) begin
            if (m_hs && in_tlast) begin
                if (cur < NS) pkt_m[cur]++;
                else drop_m++;
            end
            if ((m_hs && in_tlast) || cur < 0) cur = (selq.size() > 0) ? selq.pop_front() : -1;
            if (select_valid && srdy_m) selq.push_back(int'(select_data));
            srdy_m = (selq.size() < SD);
        end
        #1;
        drive_inputs(pushed, hs_in);
        cyc++;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while ((beat_q.size() > 0 || sel_pend.size() > 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL timeout: %0d beats and %0d selects left after %0d cycles", beat_q.size(), sel_pend.size(), n);
        end
        repeat (3) step();
    endtask

    task automatic check_sb();
        for (int i = 0; i < NS; i++) begin
            chk("sb_len", 64'(got_sb[i].size()), 64'(exp_sb[i].size()));
            for (int j = 0; j < got_sb[i].size() && j < exp_sb[i].size(); j++)
                chk("sb_beat", 64'(got_sb[i][j]), 64'(exp_sb[i][j]));
            got_sb[i].delete();
            exp_sb[i].delete();
        end
    endtask

    initial begin
        int order_exp[9] = '{2, 2, 2, 0, 0, 0, 1, 1, 1};
        int n;
        reset_model();
        phase_reset();
        repeat (3) step();
        chk("reset_select_ready", 64'(select_ready), 64'd0);
        chk("reset_in_tready", 64'(in_tready), 64'd0);
        chk("reset_out_tvalid", 64'(out_tvalid), 64'd0);
        rst_n = 1'b1;
        step();

        // Three 3-beat packets to 2,0,1 with all outputs ready.
        phase_reset();
        push_pkt(2, 3); push_pkt(0, 3); push_pkt(1, 3);
        drive_inputs(1'b0, 1'b0);
        run_until_done(100);
        chk("t1_first_beat_cycle", 64'(first_hs), 64'd2);
        chk("t1_last_beat_cycle", 64'(last_hs), 64'd10);
        chk("t1_beats", 64'(hs_cnt), 64'd9);
        for (int i = 0; i < 9 && i < dest_log.size(); i++) chk("t1_order", 64'(dest_log[i]), 64'(order_exp[i]));
        check_sb();

        // 4-beat packet to output 3 under a 1,0,0,1 ready pattern.
        phase_reset();
        tr_mode = 2;
        push_pkt(3, 4);
        drive_inputs(1'b0, 1'b0);
        run_until_done(100);
        chk("t2_beats", 64'(hs_cnt), 64'd4);
        chk("t2_tlast_once", 64'(last_beats), 64'd1);
        check_sb();
        tr_mode = 0;

        // Out-of-range select drops a 2-beat packet.
        phase_reset();
        push_pkt(5, 2);
        drive_inputs(1'b0, 1'b0);
        run_until_done(100);
        chk("t3_drop_pulses", 64'(drop_cnt_ph), 64'd1);
        chk("t3_no_out_beats", 64'(hs_cnt), 64'd0);

        // Selects run ahead of data: one goes straight to the FSM, eight fill the FIFO, the tenth waits.
        phase_reset();
        data_en = 1'b0;
        for (int i = 0; i < 10; i++) push_pkt(i % NS, 2);
        drive_inputs(1'b0, 1'b0);
        repeat (15) step();
        chk("t4_selects_accepted", 64'(sel_acc_cnt), 64'd9);
        chk("t4_select_ready_low", 64'(select_ready), 64'd0);
        data_en = 1'b1;
        run_until_done(200);
        chk("t4_all_selects", 64'(sel_acc_cnt), 64'd10);
        check_sb();

        // Reset during beat 2 of a 5-beat packet.
        phase_reset();
        push_pkt(1, 5);
        drive_inputs(1'b0, 1'b0);
        n = 0;
        while (beat_q.size() > 4 && n < 30) begin step(); n++; end
        chk("t5_reached_beat2", 64'(beat_q.size()), 64'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("t5_async_in_tready", 64'(in_tready), 64'd0);
        chk("t5_async_select_ready", 64'(select_ready), 64'd0);
        reset_model();
        beat_q.delete();
        sel_pend.delete();
        for (int i = 0; i < NS; i++) begin exp_sb[i].delete(); got_sb[i].delete(); end
        select_valid = 1'b0;
        in_tvalid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        begin
            beat_t b;
            b.d = 32'hCAFE_0001; b.k = 4'hF; b.l = 1'b1;
            beat_q.push_back(b);
            exp_sb[0].push_back({b.l, b.k, b.d});
        end
        drive_inputs(1'b0, 1'b0);
        repeat (5) step();
        chk("t5_stall_no_select", 64'(in_tready), 64'd0);
        chk("t5_stall_no_valid", 64'(out_tvalid), 64'd0);
        sel_pend.push_back(0);
        drive_inputs(1'b0, 1'b0);
        run_until_done(50);
        check_sb();

        // Eight single-beat packets alternating 0/1 back to back.
        phase_reset();
        for (int i = 0; i < 8; i++) push_pkt(i % 2, 1);
        drive_inputs(1'b0, 1'b0);
        run_until_done(100);
        chk("t6_beats", 64'(hs_cnt), 64'd8);
        chk("t6_no_bubbles", 64'(last_hs - first_hs), 64'd7);
        chk("t6_tlast_every_beat", 64'(last_beats), 64'd8);
        check_sb();

        // Random traffic: mixed destinations including drops, lengths, gaps and backpressure.
        phase_reset();
        gap_pct = 30;
        tr_mode = 1;
        for (int i = 0; i < 40; i++) push_pkt($urandom_range(0, 7), $urandom_range(1, 4));
        drive_inputs(1'b0, 1'b0);
        run_until_done(3000);
        check_sb();

`ifdef AXI_DEMUX_STATS_EN
        for (int i = 0; i < NS; i++) chk("pkt_count", 64'(pkt_count[i*32 +: 32]), 64'(pkt_m[i]));
        chk("drop_count", 64'(drop_count), 64'(drop_m));
        stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        chk("stats_clear", 64'(drop_count), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
